// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory stage: MMIO register map,
// MDR source selector encodings and the memory-unit state type.
package lc3_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    localparam logic [1:0] MDR_SEL_BUS = 2'b00;
    localparam logic [1:0] MDR_SEL_MEM = 2'b01;

    // Value loaded into MDR when a read is abandoned by the timeout
    localparam logic [15:0] MDR_TIMEOUT_VAL = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } mem_state_t;

    // Offset of a register inside the MMIO window, independent of where
    // the window is placed
    function automatic logic [15:0] reg_offset(input logic [15:0] addr);
        return addr - KBSR_ADDR;
    endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 memory-mapped I/O registers: keyboard status/data, display
// status/data, the address decode for the MMIO window and the
// keyboard/display byte handshakes.
module lc3_mmio_regs
    import lc3_pkg::*;
#(
    parameter logic [15:0] MMIO_BASE = KBSR_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_addr,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic        i_wdata_ie,
    input  logic [7:0]  i_wdata_byte,
    input  logic        i_kb_valid,
    input  logic [7:0]  i_kb_data,
    input  logic        i_dsp_ready,
    output logic        o_hit,
    output logic [15:0] o_rdata,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data
);

    localparam logic [15:0] KBSR_OFF = reg_offset(KBSR_ADDR);
    localparam logic [15:0] KBDR_OFF = reg_offset(KBDR_ADDR);
    localparam logic [15:0] DSR_OFF  = reg_offset(DSR_ADDR);
    localparam logic [15:0] DDR_OFF  = reg_offset(DDR_ADDR);

    logic        r_kb_ready;
    logic        r_kb_ie;
    logic [7:0]  r_kbdr;
    logic        r_dsr_ready;
    logic        r_dsr_ie;
    logic        r_dsp_valid;
    logic [7:0]  r_dsp_data;

    logic [15:0] w_off;
    logic        w_is_kbsr;
    logic        w_is_kbdr;
    logic        w_is_dsr;
    logic        w_is_ddr;
    logic        w_kbdr_rd;
    logic        w_kb_take;
    logic        w_dsp_accept;

    // Addresses below the base wrap to large offsets, so one compare
    // bounds the window on both sides
    assign w_off     = i_addr - MMIO_BASE;
    assign o_hit     = (w_off <= DDR_OFF);
    assign w_is_kbsr = (w_off == KBSR_OFF);
    assign w_is_kbdr = (w_off == KBDR_OFF);
    assign w_is_dsr  = (w_off == DSR_OFF);
    assign w_is_ddr  = (w_off == DDR_OFF);

    assign w_kbdr_rd    = i_rd_en & w_is_kbdr;
    // A KBDR read frees the buffer in the same cycle, so a byte arriving
    // alongside the read is kept rather than dropped
    assign w_kb_take    = i_kb_valid & (~r_kb_ready | w_kbdr_rd);
    assign w_dsp_accept = r_dsp_valid & i_dsp_ready;

    assign o_dsp_valid = r_dsp_valid;
    assign o_dsp_data  = r_dsp_data;

    // Read-data mux; DDR and the odd holes in the window read as zero
    always_comb begin
        o_rdata = 16'h0000;
        if (w_is_kbsr) begin
            o_rdata = {r_kb_ready, r_kb_ie, 14'h0000};
        end else if (w_is_kbdr) begin
            o_rdata = {8'h00, r_kbdr};
        end else if (w_is_dsr) begin
            o_rdata = {r_dsr_ready, r_dsr_ie, 14'h0000};
        end
    end

    // Register updates: keyboard capture, interrupt enables, display handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kb_ready  <= 1'b0;
            r_kb_ie     <= 1'b0;
            r_kbdr      <= 8'h00;
            r_dsr_ready <= 1'b1;
            r_dsr_ie    <= 1'b0;
            r_dsp_valid <= 1'b0;
            r_dsp_data  <= 8'h00;
        end else begin
            if (w_kb_take) begin
                r_kbdr     <= i_kb_data;
                r_kb_ready <= 1'b1;
            end else if (w_kbdr_rd) begin
                r_kb_ready <= 1'b0;
            end

            if (i_wr_en && w_is_kbsr) begin
                r_kb_ie <= i_wdata_ie;
            end
            if (i_wr_en && w_is_dsr) begin
                r_dsr_ie <= i_wdata_ie;
            end

            // A DDR write while the display is still busy is dropped
            if (w_dsp_accept) begin
                r_dsp_valid <= 1'b0;
                r_dsr_ready <= 1'b1;
            end else if (i_wr_en && w_is_ddr && r_dsr_ready) begin
                r_dsp_data  <= i_wdata_byte;
                r_dsp_valid <= 1'b1;
                r_dsr_ready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/lc3_mem_unit.sv
// LC-3 memory stage: MAR/MDR, the SRAM req/ack sequencer with timeout,
// and routing of MMIO-window accesses to the I/O register block.
module lc3_mem_unit
    import lc3_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [15:0] MMIO_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bus_in,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic [1:0]  selMDR,
    input  logic        memWE,
    output logic [15:0] mdr_out,
    output logic [15:0] mar_out,
    output logic        mem_ready,
    output logic        busy,
    output logic        mem_err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready
);

    // Last wait-cycle count value; the access is abandoned at that edge
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_state_t  r_state;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic [7:0]  r_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_mem_ready;
    logic        r_busy;
    logic        r_mem_err;

    logic        w_idle;
    logic        w_wr_req;
    logic        w_rd_req;
    logic        w_mmio_hit;
    logic [15:0] w_mmio_rdata;
    logic        w_mmio_rd;
    logic        w_mmio_wr;

    // A write request takes priority over a simultaneous memory read
    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr_req  = memWE;
    assign w_rd_req  = ldMDR & (selMDR == MDR_SEL_MEM) & ~memWE;
    assign w_mmio_rd = w_idle & w_rd_req & w_mmio_hit;
    assign w_mmio_wr = w_idle & w_wr_req & w_mmio_hit;

    assign mdr_out   = r_mdr;
    assign mar_out   = r_mar;
    assign mem_ready = r_mem_ready;
    assign busy      = r_busy;
    assign mem_err   = r_mem_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;

    lc3_mmio_regs #(
        .MMIO_BASE (MMIO_BASE)
    ) u_mmio (
        .clk          (clk),
        .reset        (reset),
        .i_addr       (r_mar),
        .i_rd_en      (w_mmio_rd),
        .i_wr_en      (w_mmio_wr),
        .i_wdata_ie   (r_mdr[14]),
        .i_wdata_byte (r_mdr[7:0]),
        .i_kb_valid   (kb_valid),
        .i_kb_data    (kb_data),
        .i_dsp_ready  (dsp_ready),
        .o_hit        (w_mmio_hit),
        .o_rdata      (w_mmio_rdata),
        .o_dsp_valid  (dsp_valid),
        .o_dsp_data   (dsp_data)
    );

    // MAR/MDR loads and the access sequencer; all handshake outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mar       <= 16'h0000;
            r_mdr       <= 16'h0000;
            r_cnt       <= 8'h00;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_mem_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_err   <= 1'b0;
        end else begin
            r_mem_ready <= 1'b0;

            if (ldMAR) begin
                r_mar <= bus_in;
            end
            if (ldMDR && (selMDR == MDR_SEL_BUS)) begin
                r_mdr <= bus_in;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wr_req) begin
                        if (w_mmio_hit) begin
                            r_state     <= ST_DONE;
                            r_mem_ready <= 1'b1;
                        end else begin
                            r_state     <= ST_WR_WAIT;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_mar;
                            r_mem_wdata <= r_mdr;
                            r_busy      <= 1'b1;
                            r_cnt       <= 8'h00;
                        end
                    end else if (w_rd_req) begin
                        if (w_mmio_hit) begin
                            r_mdr       <= w_mmio_rdata;
                            r_state     <= ST_DONE;
                            r_mem_ready <= 1'b1;
                        end else begin
                            r_state    <= ST_RD_WAIT;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= r_mar;
                            r_busy     <= 1'b1;
                            r_cnt      <= 8'h00;
                        end
                    end
                end

                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (mem_ack) begin
                        if (r_state == ST_RD_WAIT) begin
                            r_mdr <= mem_rdata;
                        end
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        if (r_state == ST_RD_WAIT) begin
                            r_mdr <= MDR_TIMEOUT_VAL;
                        end
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_mem_err   <= 1'b1;
                        r_mem_ready <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Directed bench for lc3_mem_unit with a transaction-level reference model,
// a simple SRAM responder and a per-cycle output comparator.
module tb_lc3_mem_unit;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        reset;
    logic [15:0] bus_in;
    logic        ldMAR;
    logic        ldMDR;
    logic [1:0]  selMDR;
    logic        memWE;
    logic [15:0] mdr_out;
    logic [15:0] mar_out;
    logic        mem_ready;
    logic        busy;
    logic        mem_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;

    lc3_mem_unit #(
        .TIMEOUT   (TIMEOUT),
        .MMIO_BASE (16'hFE00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus_in    (bus_in),
        .ldMAR     (ldMAR),
        .ldMDR     (ldMDR),
        .selMDR    (selMDR),
        .memWE     (memWE),
        .mdr_out   (mdr_out),
        .mar_out   (mar_out),
        .mem_ready (mem_ready),
        .busy      (busy),
        .mem_err   (mem_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .kb_valid  (kb_valid),
        .kb_data   (kb_data),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    // Reference model state
    logic [15:0] m_mar, m_mdr, m_addr, m_wdata;
    logic        m_err, m_ready, m_inflight, m_we;
    logic        m_kb_ready, m_kb_ie, m_dsr_ready, m_dsp_ie, m_dsp_valid;
    logic [7:0]  m_kbdr, m_dsp_data;

    // SRAM contents and responder latency (0 = never acknowledge)
    logic [15:0] sram [logic [15:0]];
    int ack_lat = 1;
    int req_cycles = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sram_rd(input logic [15:0] a);
        if (sram.exists(a)) return sram[a];
        return 16'h0000;
    endfunction

    function automatic bit in_mmio(input logic [15:0] a);
        return (a >= 16'hFE00) && (a <= 16'hFE06);
    endfunction

    function automatic logic [15:0] mmio_rd(input logic [15:0] a);
        case (a)
            16'hFE00: return {m_kb_ready, m_kb_ie, 14'h0};
            16'hFE02: return {8'h00, m_kbdr};
            16'hFE04: return {m_dsr_ready, m_dsp_ie, 14'h0};
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_mar = 0; m_mdr = 0; m_addr = 0; m_wdata = 0;
        m_err = 0; m_ready = 0; m_inflight = 0; m_we = 0;
        m_kb_ready = 0; m_kb_ie = 0; m_kbdr = 0;
        m_dsr_ready = 1; m_dsp_ie = 0; m_dsp_valid = 0; m_dsp_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // SRAM responder: acknowledges the ack_lat-th cycle of a request
    initial begin
        mem_ack = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            step();
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                req_cycles++;
                if (ack_lat != 0 && req_cycles == ack_lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) sram[mem_addr] = mem_wdata;
                    else        mem_rdata = sram_rd(mem_addr);
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("mar", mar_out, m_mar);
            chk("mdr", mdr_out, m_mdr);
            chk("mem_err", 16'(mem_err), 16'(m_err));
            chk("mem_ready", 16'(mem_ready), 16'(m_ready));
            chk("busy", 16'(busy), 16'(m_inflight));
            chk("mem_req", 16'(mem_req), 16'(m_inflight));
            chk("dsp_valid", 16'(dsp_valid), 16'(m_dsp_valid));
            if (m_inflight) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_we", 16'(mem_we), 16'(m_we));
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_dsp_valid) chk("dsp_data", 16'(dsp_data), 16'(m_dsp_data));
        end
    end

    task automatic set_mar(input logic [15:0] v);
        bus_in = v; ldMAR = 1;
        step();
        ldMAR = 0;
        m_mar = v;
    endtask

    task automatic set_mdr(input logic [15:0] v);
        bus_in = v; ldMDR = 1; selMDR = 2'b00;
        step();
        ldMDR = 0;
        m_mdr = v;
    endtask

    task automatic kb_strobe(input logic [7:0] d);
        kb_valid = 1; kb_data = d;
        step();
        kb_valid = 0;
        if (!m_kb_ready) begin m_kbdr = d; m_kb_ready = 1; end
    endtask

    task automatic dsp_ack();
        dsp_ready = 1;
        step();
        dsp_ready = 0;
        if (m_dsp_valid) begin m_dsp_valid = 0; m_dsr_ready = 1; end
    endtask

    // Remaining wait cycles of an SRAM access, then the DONE cycle
    task automatic finish_sram(input bit is_rd);
        int n;
        n = (ack_lat == 0) ? TIMEOUT : ack_lat;
        for (int k = 1; k <= n; k++) begin
            step();
            if (k == n) begin
                m_inflight = 0;
                m_ready = 1;
                if (ack_lat == 0) begin
                    m_err = 1;
                    if (is_rd) m_mdr = 16'hDEAD;
                end else if (is_rd) begin
                    m_mdr = sram_rd(m_addr);
                end
            end
        end
        step();
        m_ready = 0;
    endtask

    task automatic do_read(input logic kbv, input logic [7:0] kbd);
        logic [15:0] old;
        ldMDR = 1; selMDR = 2'b01; kb_valid = kbv; kb_data = kbd;
        step();
        ldMDR = 0; selMDR = 2'b00; kb_valid = 0;
        if (in_mmio(m_mar)) begin
            old = mmio_rd(m_mar);
            if (kbv && (!m_kb_ready || m_mar == 16'hFE02)) begin
                m_kbdr = kbd; m_kb_ready = 1;
            end else if (m_mar == 16'hFE02) begin
                m_kb_ready = 0;
            end
            m_mdr = old;
            m_ready = 1;
            step();
            m_ready = 0;
        end else begin
            if (kbv && !m_kb_ready) begin m_kbdr = kbd; m_kb_ready = 1; end
            m_inflight = 1; m_we = 0; m_addr = m_mar;
            finish_sram(1'b1);
        end
    endtask

    task automatic do_write(input logic also_rd);
        memWE = 1;
        if (also_rd) begin ldMDR = 1; selMDR = 2'b01; end
        step();
        memWE = 0; ldMDR = 0; selMDR = 2'b00;
        if (in_mmio(m_mar)) begin
            case (m_mar)
                16'hFE00: m_kb_ie = m_mdr[14];
                16'hFE04: m_dsp_ie = m_mdr[14];
                16'hFE06: if (m_dsr_ready) begin
                    m_dsp_data = m_mdr[7:0]; m_dsp_valid = 1; m_dsr_ready = 0;
                end
                default: ;
            endcase
            m_ready = 1;
            step();
            m_ready = 0;
        end else begin
            m_inflight = 1; m_we = 1; m_addr = m_mar; m_wdata = m_mdr;
            finish_sram(1'b0);
        end
    endtask

    initial begin
        reset = 1; bus_in = 0; ldMAR = 0; ldMDR = 0; selMDR = 0; memWE = 0;
        kb_valid = 0; kb_data = 0; dsp_ready = 0;
        model_reset();
        step(); step();
        reset = 0;
        chk_en = 1;

        // Reset state
        chk("rst_mar", mar_out, 16'h0000);
        chk("rst_mdr", mdr_out, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 16'h0000);
        chk("rst_flags", {11'h0, mem_req, mem_we, busy, mem_err, dsp_valid}, 16'h0000);

        // SRAM read, ack after 3 cycles
        sram[16'h3000] = 16'h1234;
        set_mar(16'h3000);
        ack_lat = 3;
        do_read(1'b0, 8'h00);
        chk("rd_data", mdr_out, 16'h1234);
        chk("rd_err", 16'(mem_err), 16'h0000);

        // SRAM write, ack on the first wait cycle
        set_mdr(16'hBEEF);
        set_mar(16'h4000);
        ack_lat = 1;
        do_write(1'b0);
        chk("wr_sram", sram_rd(16'h4000), 16'hBEEF);

        // DSR after reset reports display ready
        set_mar(16'hFE04);
        do_read(1'b0, 8'h00);
        chk("dsr_reset", mdr_out, 16'h8000);

        // Keyboard capture, drop while full, KBDR read clears ready
        kb_strobe(8'h41);
        set_mar(16'hFE00);
        do_read(1'b0, 8'h00);
        chk("kbsr_full", mdr_out, 16'h8000);
        kb_strobe(8'h42);
        set_mar(16'hFE02);
        do_read(1'b0, 8'h00);
        chk("kbdr_rd", mdr_out, 16'h0041);
        set_mar(16'hFE00);
        do_read(1'b0, 8'h00);
        chk("kbsr_empty", mdr_out, 16'h0000);

        // Display write and handshake
        set_mdr(16'h0058);
        set_mar(16'hFE06);
        do_write(1'b0);
        chk("dsp_valid", 16'(dsp_valid), 16'h0001);
        chk("dsp_data", 16'(dsp_data), 16'h0058);
        set_mar(16'hFE04);
        do_read(1'b0, 8'h00);
        chk("dsr_busy", mdr_out, 16'h0000);
        dsp_ack();
        do_read(1'b0, 8'h00);
        chk("dsr_ready", mdr_out, 16'h8000);

        // DDR write while the display is busy is dropped
        set_mdr(16'h0058);
        set_mar(16'hFE06);
        do_write(1'b0);
        set_mdr(16'h0059);
        do_write(1'b0);
        chk("ddr_drop", 16'(dsp_data), 16'h0058);
        dsp_ack();

        // Keyboard byte arriving in the same cycle as a KBDR read
        kb_strobe(8'h30);
        set_mar(16'hFE02);
        do_read(1'b1, 8'h31);
        chk("kb_same_old", mdr_out, 16'h0030);
        do_read(1'b0, 8'h00);
        chk("kb_same_new", mdr_out, 16'h0031);

        // KBSR write only changes the interrupt enable
        set_mdr(16'hC0FF);
        set_mar(16'hFE00);
        do_write(1'b0);
        do_read(1'b0, 8'h00);
        chk("kbsr_ie", mdr_out, 16'h4000);

        // Unmapped hole inside the MMIO window
        set_mdr(16'h1111);
        set_mar(16'hFE01);
        do_read(1'b0, 8'h00);
        chk("hole_rd", mdr_out, 16'h0000);
        do_write(1'b0);

        // Write wins over a simultaneous memory read
        set_mdr(16'hCAFE);
        set_mar(16'h4100);
        ack_lat = 2;
        do_write(1'b1);
        chk("ww_sram", sram_rd(16'h4100), 16'hCAFE);
        chk("ww_mdr", mdr_out, 16'hCAFE);

        // Read timeout
        set_mar(16'h7000);
        ack_lat = 0;
        do_read(1'b0, 8'h00);
        chk("to_mdr", mdr_out, 16'hDEAD);
        chk("to_err", 16'(mem_err), 16'h0001);

        // Reset in the middle of a read; a second request while busy is ignored
        set_mar(16'h6000);
        ldMDR = 1; selMDR = 2'b01;
        step();
        ldMDR = 0; selMDR = 2'b00;
        m_inflight = 1; m_we = 0; m_addr = 16'h6000;
        step(); step();
        bus_in = 16'h5000; ldMAR = 1; memWE = 1; ldMDR = 1; selMDR = 2'b01;
        step();
        ldMAR = 0; memWE = 0; ldMDR = 0; selMDR = 2'b00;
        m_mar = 16'h5000;
        step();
        reset = 1;
        step();
        reset = 0;
        model_reset();
        chk("mid_rst_req", 16'(mem_req), 16'h0000);
        chk("mid_rst_mar", mar_out, 16'h0000);
        chk("mid_rst_err", 16'(mem_err), 16'h0000);
        repeat (4) step();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
